// File: rtl/inta_sequencer_pkg.sv
// Shared definitions for the 8259A interrupt-acknowledge sequencer: FSM states,
// vector width and the IR7 low bits a spurious interrupt produces.
package inta_sequencer_pkg;

  localparam int PIC_VEC_W = 8;

  localparam logic [2:0] IR7_LOW_BITS = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_P1        = 3'd1,
    ST_GAP       = 3'd2,
    ST_P2        = 3'd3,
    ST_DELIVER   = 3'd4,
    ST_WAIT_DROP = 3'd5
  } state_e;

endpackage

// File: rtl/inta_sequencer_sync_ff.sv
// Reset-clearable multi-flop synchroniser for a single asynchronous level.
// Output follows the input after STAGES clk edges; no backpressure.
module inta_sequencer_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// Two-pulse 8259A INTA master: captures the vector on pulse 2, vec_valid 1+2*PULSE+GAP cycles after INT.
// Holds vec_valid/vec_data until vec_ready; no new cycle until INT drops after delivery.
module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 int_in,
  input  logic                 int_enable,
  input  logic [PIC_VEC_W-1:0] dbus_in,
  output logic                 inta_n,
  output logic                 cs_n,
  output logic                 rd_n,
  output logic                 vec_valid,
  output logic [PIC_VEC_W-1:0] vec_data,
  input  logic                 vec_ready,
  output logic                 spurious,
  output logic                 busy
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic int_s;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 spur_pend_q, spur_pend_d;
  logic [PIC_VEC_W-1:0] vec_data_q, vec_data_d;
  logic                 spurious_q, spurious_d;
  logic                 inta_n_q, inta_n_d;
  logic                 strobe_n_q, strobe_n_d;
  logic                 vec_valid_q, vec_valid_d;
  logic                 busy_q, busy_d;

  inta_sequencer_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_in),
    .q     (int_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    spur_pend_d = spur_pend_q;
    vec_data_d  = vec_data_q;
    spurious_d  = spurious_q;
    case (state_q)
      ST_IDLE: begin
        if (int_s && int_enable) begin
          state_d = ST_P1;
          cnt_d   = '0;
        end
      end
      ST_P1: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        // INT already gone just before pulse 2 means the PIC will answer with IR7
        if (cnt_q == GAP_LAST) begin
          spur_pend_d = ~int_s;
          state_d     = ST_P2;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_P2: begin
        if (cnt_q == PULSE_LAST) begin
          vec_data_d = dbus_in;
          spurious_d = spur_pend_q;
          state_d    = ST_DELIVER;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DELIVER: begin
        if (vec_ready) begin
          state_d = ST_WAIT_DROP;
        end
      end
      ST_WAIT_DROP: begin
        if (!int_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so every strobe is a flop output
    inta_n_d    = !((state_d == ST_P1) || (state_d == ST_P2));
    strobe_n_d  = (state_d != ST_P2);
    vec_valid_d = (state_d == ST_DELIVER);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      spur_pend_q <= 1'b0;
      vec_data_q  <= '0;
      spurious_q  <= 1'b0;
      inta_n_q    <= 1'b1;
      strobe_n_q  <= 1'b1;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      spur_pend_q <= spur_pend_d;
      vec_data_q  <= vec_data_d;
      spurious_q  <= spurious_d;
      inta_n_q    <= inta_n_d;
      strobe_n_q  <= strobe_n_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign inta_n    = inta_n_q;
  assign cs_n      = strobe_n_q;
  assign rd_n      = strobe_n_q;
  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
  assign spurious  = spurious_q;
  assign busy      = busy_q;

endmodule
